// File: rtl/apb_cmd_master.sv
// Single-outstanding APB3 requester: takes one command on a valid/ready port,
// runs SETUP/ACCESS with wait states and a timeout, returns a registered response.
module apb_cmd_master #(
    parameter int APB_WIDTH      = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic                  CMD_WRITE,
    input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [APB_WIDTH-1:0]  CMD_WDATA,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [APB_WIDTH-1:0]  RSP_RDATA,
    output logic                  RSP_ERR,
    output logic                  RSP_TIMEOUT,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [APB_WIDTH-1:0]  PWDATA,
    input  logic [APB_WIDTH-1:0]  PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    output logic                  BUSY
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);

    state_t      state;
    logic [15:0] wait_cnt;
    logic        to_hit;

    // Abort on the ACCESS cycle that would make the count reach the limit;
    // PREADY is checked first so a same-cycle completion still succeeds.
    assign to_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == TO_LIM - 16'd1);

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            CMD_READY   <= 1'b0;
            RSP_VALID   <= 1'b0;
            RSP_RDATA   <= '0;
            RSP_ERR     <= 1'b0;
            RSP_TIMEOUT <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            BUSY        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (CMD_VALID && CMD_READY) begin
                        PWRITE    <= CMD_WRITE;
                        PADDR     <= CMD_ADDR;
                        PWDATA    <= CMD_WDATA;
                        PSEL      <= 1'b1;
                        PENABLE   <= 1'b0;
                        CMD_READY <= 1'b0;
                        BUSY      <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= SETUP;
                    end else begin
                        CMD_READY <= 1'b1;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        RSP_RDATA   <= PWRITE ? '0 : PRDATA;
                        RSP_ERR     <= PSLVERR;
                        RSP_TIMEOUT <= 1'b0;
                        RSP_VALID   <= 1'b1;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        state       <= RESP;
                    end else if (to_hit) begin
                        RSP_RDATA   <= '0;
                        RSP_ERR     <= 1'b1;
                        RSP_TIMEOUT <= 1'b1;
                        RSP_VALID   <= 1'b1;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                RESP: begin
                    if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        CMD_READY <= 1'b1;
                        BUSY      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: vector table of single transfers with a
// behavioural APB slave, plus back-to-back and mid-transfer reset sequences.
module tb_apb_cmd_master;

    logic        PCLK, PRESETN;
    logic        CMD_VALID, CMD_READY, CMD_WRITE;
    logic [7:0]  CMD_ADDR;
    logic [31:0] CMD_WDATA;
    logic        RSP_VALID, RSP_READY, RSP_ERR, RSP_TIMEOUT;
    logic [31:0] RSP_RDATA;
    logic        PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR, BUSY;

    int total = 0;
    int bad   = 0;

    apb_cmd_master #(.APB_WIDTH(32), .ADDR_WIDTH(8), .TIMEOUT_CYCLES(4)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
        .RSP_ERR(RSP_ERR), .RSP_TIMEOUT(RSP_TIMEOUT),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .BUSY(BUSY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        bit          write;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          waits;   // PREADY rises on ACCESS cycle waits+1
        logic [31:0] prdata;
        bit          err;
        int          hold;    // cycles RSP_READY stays low
        logic [31:0] e_rdata;
        bit          e_err;
        bit          e_to;
        int          e_lat;   // cycles from accept edge to RSP_VALID
        int          e_pen;   // cycles PENABLE is high
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        @(negedge PCLK);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  n, acc, lat;
        bit  done, proto_ok, hold_ok;
        n = 0;
        while (!CMD_READY && n < 10) begin tick(); n++; end
        chk($sformatf("v%0d cmd_ready", idx), {31'b0, CMD_READY}, 1);
        CMD_VALID = 1'b1; CMD_WRITE = v.write; CMD_ADDR = v.addr; CMD_WDATA = v.wdata;
        tick();
        CMD_VALID = 1'b0; CMD_ADDR = ~v.addr; CMD_WDATA = ~v.wdata; CMD_WRITE = ~v.write;
        chk($sformatf("v%0d setup", idx), {30'b0, PSEL, PENABLE}, 32'h2);
        acc = 0; lat = 1; done = 0; proto_ok = 1;
        while (!done && lat < 40) begin
            if (RSP_VALID) done = 1;
            else begin
                if (PENABLE && !PSEL) proto_ok = 0;
                if (CMD_READY) proto_ok = 0;
                if (PSEL && (PADDR !== v.addr || PWRITE !== v.write || PWDATA !== v.wdata))
                    proto_ok = 0;
                if (PSEL && PENABLE) acc++;
                PREADY  = PSEL && PENABLE && (acc == v.waits + 1);
                PRDATA  = PREADY ? v.prdata : 32'hBAD0_BAD0;
                PSLVERR = PREADY ? v.err : 1'b1;
                tick();
                lat++;
            end
        end
        PREADY = 1'b0; PSLVERR = 1'b0;
        chk($sformatf("v%0d latency", idx), lat, v.e_lat);
        chk($sformatf("v%0d penable_cycles", idx), acc, v.e_pen);
        chk($sformatf("v%0d rdata", idx), RSP_RDATA, v.e_rdata);
        chk($sformatf("v%0d err", idx), {31'b0, RSP_ERR}, {31'b0, v.e_err});
        chk($sformatf("v%0d timeout", idx), {31'b0, RSP_TIMEOUT}, {31'b0, v.e_to});
        chk($sformatf("v%0d protocol", idx), {31'b0, proto_ok}, 1);
        hold_ok = 1;
        for (int h = 0; h < v.hold; h++) begin
            tick();
            if (RSP_VALID !== 1'b1 || RSP_RDATA !== v.e_rdata || RSP_ERR !== v.e_err ||
                PSEL || PENABLE || CMD_READY || !BUSY) hold_ok = 0;
        end
        if (v.hold > 0) chk($sformatf("v%0d backpressure", idx), {31'b0, hold_ok}, 1);
        RSP_READY = 1'b1;
        tick();
        RSP_READY = 1'b0;
        chk($sformatf("v%0d rsp_drop", idx), {30'b0, RSP_VALID, BUSY}, 0);
        chk($sformatf("v%0d ready_again", idx), {31'b0, CMD_READY}, 1);
    endtask

    initial begin
        int acc_t[3];
        int na, cyc;
        bit quiet;

        //          wr    addr   wdata         wt  prdata        err hold e_rdata       e_err e_to lat pen
        vecs[0] = '{1'b1, 8'h01, 32'h0000_00A5, 0, 32'h0000_DEAD, 1'b0, 0, 32'h0,        1'b0, 1'b0, 3, 1};
        vecs[1] = '{1'b0, 8'h00, 32'h1111_1111, 3, 32'h0000_005A, 1'b0, 0, 32'h0000_005A, 1'b0, 1'b0, 6, 4};
        vecs[2] = '{1'b1, 8'h03, 32'h0000_0033, 0, 32'hFFFF_FFFF, 1'b1, 0, 32'h0,        1'b1, 1'b0, 3, 1};
        vecs[3] = '{1'b0, 8'h02, 32'h0,         99, 32'h0000_0077, 1'b0, 0, 32'h0,       1'b1, 1'b1, 6, 4};
        vecs[4] = '{1'b0, 8'h02, 32'h0,         3, 32'h0000_0033, 1'b0, 0, 32'h0000_0033, 1'b0, 1'b0, 6, 4};
        vecs[5] = '{1'b0, 8'h04, 32'h0,         0, 32'h0000_0012, 1'b0, 5, 32'h0000_0012, 1'b0, 1'b0, 3, 1};
        vecs[6] = '{1'b0, 8'h05, 32'h0,         1, 32'h0000_00C3, 1'b1, 0, 32'h0000_00C3, 1'b1, 1'b0, 4, 2};
        vecs[7] = '{1'b1, 8'hFF, 32'hFFFF_FFFF, 99, 32'h0,        1'b0, 0, 32'h0,        1'b1, 1'b1, 6, 4};

        PRESETN = 1'b0; CMD_VALID = 1'b0; CMD_WRITE = 1'b0; CMD_ADDR = '0; CMD_WDATA = '0;
        RSP_READY = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        tick(); tick();
        chk("reset ctrl", {24'b0, CMD_READY, RSP_VALID, RSP_ERR, RSP_TIMEOUT, PSEL, PENABLE, PWRITE, BUSY}, 0);
        chk("reset paddr", {24'b0, PADDR}, 0);
        chk("reset pwdata", PWDATA, 0);
        chk("reset rdata", RSP_RDATA, 0);
        PRESETN = 1'b1;
        tick();
        chk("release cmd_ready", {30'b0, CMD_READY, BUSY}, 32'h2);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Back-to-back: slave always ready, sink always ready.
        CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 8'h09; CMD_WDATA = 32'h0;
        PREADY = 1'b1; PRDATA = 32'h0000_0042; RSP_READY = 1'b1;
        na = 0; cyc = 0;
        while (na < 3 && cyc < 40) begin
            if (CMD_READY) begin acc_t[na] = cyc; na++; end
            tick();
            cyc++;
        end
        CMD_VALID = 1'b0;
        chk("b2b accepts", na, 3);
        chk("b2b interval1", acc_t[1] - acc_t[0], 4);
        chk("b2b interval2", acc_t[2] - acc_t[1], 4);
        for (int i = 0; i < 6; i++) tick();
        chk("b2b drained", {30'b0, BUSY, CMD_READY}, 32'h1);
        PREADY = 1'b0; RSP_READY = 1'b0;

        // Reset during ACCESS wait states.
        CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 8'h07;
        tick();
        CMD_VALID = 1'b0;
        tick(); tick();
        chk("pre-reset in access", {30'b0, PSEL, PENABLE}, 32'h3);
        PRESETN = 1'b0;
        tick();
        chk("mid reset", {27'b0, PSEL, PENABLE, RSP_VALID, BUSY, CMD_READY}, 0);
        PRESETN = 1'b1;
        quiet = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (RSP_VALID || PSEL || PENABLE || BUSY) quiet = 0;
        end
        chk("no response after reset", {31'b0, quiet}, 1);
        run_vec(8, '{1'b0, 8'h06, 32'h0, 0, 32'h0000_0099, 1'b0, 0, 32'h0000_0099, 1'b0, 1'b0, 3, 1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- Single-outstanding APB3 initiator (requester side) driving a CoreGPIO-style APB slave, e.g. Minimal_SoC GPIO, from fabric logic in place of the bench BFM.
- Accepts one command at a time (read/write, address, data) on a valid/ready port.
- Runs the APB SETUP/ACCESS phases, honours PREADY wait states, and returns read data plus error status on a valid/ready response port.
- A bounded wait-state timeout stops a hung slave from stalling the fabric.

Parameters:
- APB_WIDTH, 32, data width of PWDATA/PRDATA/CMD_WDATA/RSP_RDATA (8, 16 or 32).
- ADDR_WIDTH, 8, width of PADDR/CMD_ADDR.
- TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles with PREADY low before abort; 0 disables timeout; counter is 16 bits wide.

Ports:
- PCLK  in  1  system/APB clock; all logic on rising edge.
- PRESETN  in  1  reset, synchronous, active-low.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  command accepted when CMD_VALID&CMD_READY.
- CMD_WRITE  in  1  1=write, 0=read.
- CMD_ADDR  in  ADDR_WIDTH  target address.
- CMD_WDATA  in  APB_WIDTH  write data.
- RSP_VALID  out  1  response present.
- RSP_READY  in  1  response consumed when RSP_VALID&RSP_READY.
- RSP_RDATA  out  APB_WIDTH  read data (0 for writes/timeout).
- RSP_ERR  out  1  PSLVERR captured, or timeout.
- RSP_TIMEOUT  out  1  transfer aborted by timeout.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  APB_WIDTH  APB write data.
- PRDATA  in  APB_WIDTH  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.
- BUSY  out  1  state != IDLE.

Behaviour:
- Reset is synchronous and active-low: on a PCLK edge with PRESETN=0, state=IDLE and every output is 0, except CMD_READY=1 after release.
- Reset mid-transfer drops PSEL/PENABLE at that edge; no response is produced for the aborted command.
- All outputs are registered.
- FSM states IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - CMD_READY=1.
  - On accept, latch CMD_WRITE/ADDR/WDATA into PWRITE/PADDR/PWDATA.
  - Go to SETUP, with PSEL=1 and PENABLE=0 from the next cycle.
- SETUP (exactly 1 cycle): go to ACCESS unconditionally, with PENABLE=1.
- ACCESS:
  - On PREADY=1: capture PRDATA into RSP_RDATA if read (0 if write) and PSLVERR into RSP_ERR; RSP_TIMEOUT=0; PSEL=PENABLE=0; go to RESP with RSP_VALID=1.
  - On PREADY=0: increment the wait counter.
  - When TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES with PREADY still low: PSEL=PENABLE=0, RSP_RDATA=0, RSP_ERR=1, RSP_TIMEOUT=1; go to RESP.
  - PREADY=1 in the same cycle the counter hits the limit counts as a normal completion; success wins.
- RESP:
  - RSP_VALID=1; RSP_* are held stable until the handshake.
  - On RSP_READY=1: go to IDLE, RSP_VALID=0 next cycle.
- PADDR/PWRITE/PWDATA are stable from SETUP through the end of ACCESS and hold their last value while idle.
- CMD_READY=0 in SETUP/ACCESS/RESP, so only one transfer is outstanding.
- PSEL is never high in IDLE/RESP. PENABLE is never high without PSEL.
- Latency with zero wait states and RSP_READY=1:
  - Accept at edge N; PSEL at N+1; PENABLE at N+2.
  - RSP_VALID at N+3; next accept at N+4.
  - Total: 4-cycle issue interval.
- Each wait state adds 1 cycle.
- The wait counter clears on entry to SETUP.
- PRDATA is sampled only in the cycle where PENABLE&PREADY are both high.

Test Plan:
- Write, PREADY tied 1: CMD write addr 0x01 data 0x000000A5 -> PSEL high 1 cycle before PENABLE, PWDATA=0xA5 throughout, RSP_VALID 3 cycles after accept, RSP_RDATA=0, RSP_ERR=0.
- Read with 3 wait states: addr 0x00, slave returns 0x0000005A on 4th ACCESS cycle -> PENABLE high 4 cycles, RSP_RDATA=0x5A, RSP_ERR=0, RSP_TIMEOUT=0.
- Slave error: write addr 0x03 with PSLVERR=1 at PREADY -> RSP_ERR=1, RSP_TIMEOUT=0, next command accepted normally.
- Timeout, TIMEOUT_CYCLES=4, PREADY held 0 -> PSEL/PENABLE drop after 4 ACCESS cycles, RSP_ERR=1, RSP_TIMEOUT=1, RSP_RDATA=0. Also PREADY=1 exactly on the 4th cycle -> normal completion.
- Backpressure: RSP_READY low 5 cycles after a read of 0x12 -> RSP_VALID/RSP_RDATA stable, CMD_READY=0, no new APB activity; then back-to-back commands give a 4-cycle interval.
- Reset mid-ACCESS: PRESETN=0 for 1 cycle during wait states -> PSEL/PENABLE/RSP_VALID=0 at that edge, no response emitted, fresh command completes correctly.
